// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Optional statistics counters are enabled with the IFQ_STATS_EN macro (see inst_fetch_queue).
package ifq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MISS  = 2'd2
    } ifq_state_e;

    // Layout of one queue entry at the default widths.
    // The top level builds the same {inst, ptr} layout at its own parameter widths.
    localparam int IFQ_DEF_WORD = 16;
    localparam int IFQ_DEF_ADDR = 16;

    typedef struct packed {
        logic [IFQ_DEF_WORD-1:0] inst;
        logic [IFQ_DEF_ADDR-1:0] ptr;
    } ifq_entry_t;

    // Bits needed to index 'value' items; never less than one so that
    // single-cycle miss latencies still get a legal counter.
    function automatic int ifq_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular-buffer FIFO holding fetched {inst, ptr} entries.
// The head is read combinationally from registered storage; flush wins over push/pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [ifq_clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]              head
);

    localparam int PW = ifq_clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            do_push = push && (count_q < FULL);
            do_pop  = pop && (count_q != '0);
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Register storage and pointers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch with a miss-latency stall and a prefetch FIFO to decode.
// Define IFQ_STATS_EN to add the hit_count / miss_count statistics outputs.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 4,
    parameter int MISS_LATENCY = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_enable,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_ptr,
    output logic [ADDR_WIDTH-1:0] cache_ptr,
    output logic                  cache_enable,
    input  logic                  cache_hit,
    input  logic [WORD_SIZE-1:0]  cache_inst,
    output logic [WORD_SIZE-1:0]  out,
    output logic [ADDR_WIDTH-1:0] out_ptr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int CW = ifq_clog2(DEPTH) + 1;
    localparam int MW = ifq_clog2(MISS_LATENCY);
    localparam int EW = WORD_SIZE + ADDR_WIDTH;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_M1   = CW'(DEPTH - 1);
    localparam logic [MW-1:0] MISS_LOAD = MW'(MISS_LATENCY - 1);

    typedef struct packed {
        logic [WORD_SIZE-1:0]  inst;
        logic [ADDR_WIDTH-1:0] ptr;
    } entry_t;

    ifq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [MW-1:0]         miss_cnt_q, miss_cnt_d;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_after_pop;
    entry_t                push_e;
    entry_t                head_e;

    // A pop coinciding with a redirect is dropped; the flush discards the queue anyway.
    assign pop             = out_valid && out_ready && !redirect;
    assign count_after_pop = count - CW'(pop);
    assign push_e          = '{inst: cache_inst, ptr: pc_q};

    // Fetch FSM next-state: redirect overrides everything, otherwise issue/stall/capture.
    // The stay-in-FETCH decision looks at occupancy after this cycle's push and pop so
    // no request is presented once the queue has filled.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        miss_cnt_d = miss_cnt_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush      = 1'b1;
            pc_d       = redirect_ptr;
            miss_cnt_d = '0;
            state_d    = fetch_enable ? ST_FETCH : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fetch_enable && (count < FULL)) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (count < FULL) begin
                        if (cache_hit) begin
                            push    = 1'b1;
                            pc_d    = pc_q + ADDR_WIDTH'(1);
                            state_d = (fetch_enable && (count_after_pop < FULL_M1)) ? ST_FETCH : ST_IDLE;
                        end else begin
                            miss_cnt_d = MISS_LOAD;
                            state_d    = ST_MISS;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MISS: begin
                    if (miss_cnt_q == '0) begin
                        push    = 1'b1;
                        pc_d    = pc_q + ADDR_WIDTH'(1);
                        state_d = (fetch_enable && (count_after_pop < FULL_M1)) ? ST_FETCH : ST_IDLE;
                    end else begin
                        miss_cnt_d = miss_cnt_q - MW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Register FSM state, fetch pointer and miss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_e),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head_e)
    );

    assign cache_enable = (state_q != ST_IDLE);
    assign cache_ptr    = pc_q;
    assign busy         = (state_q == ST_MISS);
    assign out          = head_e.inst;
    assign out_ptr      = head_e.ptr;
    assign out_valid    = (count != '0);

`ifdef IFQ_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        hit_evt;
    logic        miss_evt;

    assign hit_evt  = !redirect && (state_q == ST_FETCH) && (count < FULL) && cache_hit;
    assign miss_evt = !redirect && (state_q == ST_FETCH) && (count < FULL) && !cache_hit;

    // Free-running event counters; only reset clears them.
    always_comb begin
        hit_count_d  = hit_count_q + 32'(hit_evt);
        miss_count_d = miss_count_q + 32'(miss_evt);
    end

    // Register statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction fetch unit with a prefetch queue. It walks a sequential fetch pointer and requests each instruction from the instruction cache. Cache misses are modelled with a cycle-accurate miss-latency counter instead of a delay. Fetched words and their addresses are buffered in a FIFO that drains to decode through a valid/ready handshake. A redirect input flushes the queue and restarts fetch for branches.

## Interface
Parameters:
- WORD_SIZE, 16, instruction width in bits
- ADDR_WIDTH, 16, fetch pointer width in bits
- DEPTH, 4, queue entries; power of two, at least 2
- MISS_LATENCY, 10, cycles a miss stalls before data is taken; at least 1

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- fetch_enable  in  1  permits new cache requests
- redirect  in  1  flush and restart at redirect_ptr
- redirect_ptr  in  ADDR_WIDTH  restart address
- cache_ptr  out  ADDR_WIDTH  address presented to the cache
- cache_enable  out  1  cache request strobe
- cache_hit  in  1  combinational hit for cache_ptr in the same cycle
- cache_inst  in  WORD_SIZE  combinational data for cache_ptr
- out  out  WORD_SIZE  queue head instruction
- out_ptr  out  ADDR_WIDTH  address of the queue head
- out_valid  out  1  queue non-empty
- out_ready  in  1  consumer accepts the head
- busy  out  1  miss in progress

## Operation
- States:
  - IDLE: no request.
  - FETCH: requesting.
  - MISS: counting the miss latency.
- IDLE→FETCH when fetch_enable=1 and count<DEPTH.
- FETCH behaviour:
  - cache_enable=1, cache_ptr=pc.
  - Hit: push {cache_inst, pc}, pc←pc+1, stay in FETCH.
  - Miss: load miss counter with MISS_LATENCY-1, go to MISS.
- FETCH→IDLE when fetch_enable=0 or count==DEPTH. Issue only when count<DEPTH. A pop in the same cycle does not enable a push when full.
- MISS behaviour:
  - cache_enable=1; cache_ptr held at pc; busy=1.
  - Counter decrements each cycle.
  - At counter 0: push {cache_inst, pc} regardless of cache_hit, pc←pc+1, then go to FETCH if fetch_enable=1 and count after push <DEPTH, else IDLE.
  - fetch_enable dropping during MISS does not abort the miss.
- Pop: when out_valid && out_ready at a clock edge, head advances. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, any state):
  - Queue emptied, pc←redirect_ptr, miss aborted, no push that cycle.
  - Next state is FETCH if fetch_enable=1, else IDLE.
  - A pop in the redirect cycle is discarded.
- pc wraps from 2^ADDR_WIDTH-1 to 0.
- Reset values: pc=0, count=0, state=IDLE, out=0, out_ptr=0, out_valid=0, cache_enable=0, cache_ptr=0, busy=0.
- Reset mid-miss aborts immediately. No entry is written.

## Timing
- Hit request in cycle N: entry visible (out_valid=1) in cycle N+1.
- Miss detected in cycle N: busy=1 in cycles N+1 through N+MISS_LATENCY. Data captured at the end of cycle N+MISS_LATENCY. Entry visible in cycle N+MISS_LATENCY+1.
- Sustained hits with a ready consumer give one instruction per cycle.
- out and out_ptr are read combinationally from registered queue storage. out_valid is derived from the registered count.
- cache_enable, cache_ptr and busy are decoded from registered state and pc. They carry no combinational path from cache_hit.

## Configuration
- IFQ_STATS_EN defined:
  - Adds outputs hit_count (out, 32) and miss_count (out, 32).
  - Each increments by one per hit push or per miss entry.
  - Both wrap at 2^32 and are cleared only by rst.
  - Redirect does not clear them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package ifq_pkg holds:
  - state enum (IDLE, FETCH, MISS);
  - the log2 helper for the count and miss-counter widths;
  - the queue entry type {inst, ptr}.
- One sub-module, ifq_fifo, parametrised by DEPTH and entry width. It provides push, pop and flush ports, count, and head output.
- FSM, pc and miss counter stay in the top level.

## Test plan
- Reset then fetch_enable=1, cache always hits with cache_inst=ptr+0x100, out_ready=1 → outputs 0x100, 0x101, 0x102 at pointers 0, 1, 2, one per cycle from cycle 1.
- Miss at ptr 3 with MISS_LATENCY=10 → busy high for 10 cycles; entry {cache_inst, 3} appears in cycle 11 after detection; fetch resumes at ptr 4.
- out_ready=0 with DEPTH=4, all hits → exactly 4 entries, then cache_enable=0. Raising out_ready for one cycle → one pop, one new fetch.
- Redirect to 0x0040 mid-miss with 2 entries queued → out_valid=0 next cycle, busy=0, next request at cache_ptr=0x0040, no stale entry delivered.
- pc at 0xFFFF with hit → next cache_ptr=0x0000. Under IFQ_STATS_EN, 5 hits and 2 misses give hit_count=5, miss_count=2; asserting rst mid-miss zeros both and all outputs asynchronously.
